// File: rtl/eh2_dec_trigger_hit_ctl.sv
// Decode trigger hit control: chains raw matches, registers fire/halt/exc, and arbitrates
// sticky per-thread hit write-back. Optional hit counters under TRIGGER_HIT_COUNT_EN.
module eh2_dec_trigger_hit_ctl #(
    parameter int unsigned NUM_THREADS = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_THREADS-1:0][3:0]  trig_chain,
    input  logic [NUM_THREADS-1:0][3:0]  trig_action,
    input  logic                         i0_valid,
    input  logic                         i1_valid,
    input  logic                         i0_tid,
    input  logic                         i1_tid,
    input  logic [3:0]                   i0_match,
    input  logic [3:0]                   i1_match,
    input  logic [NUM_THREADS-1:0]       flush_d,
    output logic [3:0]                   i0_fire,
    output logic [3:0]                   i1_fire,
    output logic                         i0_halt,
    output logic                         i0_exc,
    output logic                         i1_halt,
    output logic                         i1_exc,
    output logic                         hit_wr_valid,
    output logic                         hit_wr_tid,
    output logic [3:0]                   hit_wr_mask,
    input  logic                         hit_wr_ready
`ifdef TRIGGER_HIT_COUNT_EN
    ,
    output logic [NUM_THREADS-1:0][15:0] hit_count
`endif
);

    typedef enum logic [0:0] {StIdle, StReq} state_e;

    // Chained pairs fire together only when both members match.
    function automatic logic [3:0] chain_fn(input logic [3:0] m, input logic [3:0] c);
        logic [3:0] f;
        f = m;
        if (c[0]) begin
            f[0] = m[0] & m[1];
            f[1] = m[0] & m[1];
        end
        if (c[2]) begin
            f[2] = m[2] & m[3];
            f[3] = m[2] & m[3];
        end
        return f;
    endfunction

    function automatic logic other_thread(input logic t);
        return (NUM_THREADS > 1) ? ~t : 1'b0;
    endfunction

    logic                        i0_t, i1_t;
    logic [3:0]                  i0_qv, i1_qv;
    logic [3:0]                  i0_fire_d, i1_fire_d;
    logic                        i0_halt_d, i0_exc_d, i1_halt_d, i1_exc_d;
    logic [NUM_THREADS-1:0][3:0] pend_q, pend_d, pend_set, pend_clr;

    state_e     state_q, state_d;
    logic       valid_q, valid_d;
    logic       tid_q, tid_d;
    logic [3:0] mask_q, mask_d;
    logic       ptr_q, ptr_d;
    logic       start_ptr, sel, load, any_pend;

    always_comb begin
        i0_t      = (NUM_THREADS > 1) ? i0_tid : 1'b0;
        i1_t      = (NUM_THREADS > 1) ? i1_tid : 1'b0;
        i0_qv     = chain_fn(i0_match, trig_chain[i0_t]) & {4{i0_valid & ~flush_d[i0_t]}};
        i1_qv     = chain_fn(i1_match, trig_chain[i1_t]) & {4{i1_valid & ~flush_d[i1_t]}};
        i0_fire_d = i0_qv;
        i1_fire_d = i1_qv;
        i0_halt_d = |(i0_qv & trig_action[i0_t]);
        i0_exc_d  = |(i0_qv & ~trig_action[i0_t]);
        i1_halt_d = |(i1_qv & trig_action[i1_t]);
        i1_exc_d  = |(i1_qv & ~trig_action[i1_t]);
        for (int unsigned t = 0; t < NUM_THREADS; t++) begin
            pend_set[t] = ((32'(i0_t) == t) ? i0_qv : 4'b0000) |
                          ((32'(i1_t) == t) ? i1_qv : 4'b0000);
        end
    end

    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        tid_d     = tid_q;
        mask_d    = mask_q;
        ptr_d     = ptr_q;
        start_ptr = ptr_q;
        load      = 1'b0;
        sel       = 1'b0;
        pend_clr  = '0;
        any_pend  = |pend_q;

        unique case (state_q)
            StIdle: begin
                load = any_pend;
            end
            StReq: begin
                if (hit_wr_ready) begin
                    ptr_d     = other_thread(tid_q);
                    start_ptr = ptr_d;
                    if (any_pend) begin
                        load = 1'b1;
                    end else begin
                        state_d = StIdle;
                        valid_d = 1'b0;
                        tid_d   = 1'b0;
                        mask_d  = 4'b0000;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                valid_d = 1'b0;
            end
        endcase

        if (load) begin
            sel           = (pend_q[start_ptr] != 4'b0000) ? start_ptr : other_thread(start_ptr);
            tid_d         = sel;
            mask_d        = pend_q[sel];
            pend_clr[sel] = pend_q[sel];
            valid_d       = 1'b1;
            state_d       = StReq;
        end

        // Set wins over clear so a hit arriving while being latched is not lost.
        for (int unsigned t = 0; t < NUM_THREADS; t++) begin
            pend_d[t] = (pend_q[t] & ~pend_clr[t]) | pend_set[t];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            valid_q <= 1'b0;
            tid_q   <= 1'b0;
            mask_q  <= 4'b0000;
            ptr_q   <= 1'b0;
            pend_q  <= '0;
            i0_fire <= 4'b0000;
            i1_fire <= 4'b0000;
            i0_halt <= 1'b0;
            i0_exc  <= 1'b0;
            i1_halt <= 1'b0;
            i1_exc  <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            tid_q   <= tid_d;
            mask_q  <= mask_d;
            ptr_q   <= ptr_d;
            pend_q  <= pend_d;
            i0_fire <= i0_fire_d;
            i1_fire <= i1_fire_d;
            i0_halt <= i0_halt_d;
            i0_exc  <= i0_exc_d;
            i1_halt <= i1_halt_d;
            i1_exc  <= i1_exc_d;
        end
    end

    assign hit_wr_valid = valid_q;
    assign hit_wr_tid   = tid_q;
    assign hit_wr_mask  = mask_q;

`ifdef TRIGGER_HIT_COUNT_EN
    logic [NUM_THREADS-1:0][15:0] cnt_q, cnt_d;
    logic [NUM_THREADS-1:0][3:0]  cnt_inc;
    logic [16:0]                  cnt_sum;

    always_comb begin
        cnt_sum = 17'd0;
        for (int unsigned t = 0; t < NUM_THREADS; t++) begin
            cnt_inc[t] = 4'($countones((32'(i0_t) == t) ? i0_qv : 4'b0000)) +
                         4'($countones((32'(i1_t) == t) ? i1_qv : 4'b0000));
            cnt_sum    = {1'b0, cnt_q[t]} + {13'd0, cnt_inc[t]};
            cnt_d[t]   = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hit_count = cnt_q;
`endif

endmodule

// File: tb/tb_eh2_dec_trigger_hit_ctl.sv
// Directed self-checking bench for eh2_dec_trigger_hit_ctl (two threads).
module tb_eh2_dec_trigger_hit_ctl;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0][3:0]  trig_chain, trig_action;
    logic             i0_valid, i1_valid, i0_tid, i1_tid;
    logic [3:0]       i0_match, i1_match;
    logic [1:0]       flush_d;
    logic [3:0]       i0_fire, i1_fire;
    logic             i0_halt, i0_exc, i1_halt, i1_exc;
    logic             hit_wr_valid, hit_wr_tid;
    logic [3:0]       hit_wr_mask;
    logic             hit_wr_ready;
`ifdef TRIGGER_HIT_COUNT_EN
    logic [1:0][15:0] hit_count;
`endif

    int checks = 0;
    int errors = 0;

    eh2_dec_trigger_hit_ctl #(.NUM_THREADS(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .trig_chain   (trig_chain),
        .trig_action  (trig_action),
        .i0_valid     (i0_valid),
        .i1_valid     (i1_valid),
        .i0_tid       (i0_tid),
        .i1_tid       (i1_tid),
        .i0_match     (i0_match),
        .i1_match     (i1_match),
        .flush_d      (flush_d),
        .i0_fire      (i0_fire),
        .i1_fire      (i1_fire),
        .i0_halt      (i0_halt),
        .i0_exc       (i0_exc),
        .i1_halt      (i1_halt),
        .i1_exc       (i1_exc),
        .hit_wr_valid (hit_wr_valid),
        .hit_wr_tid   (hit_wr_tid),
        .hit_wr_mask  (hit_wr_mask),
`ifdef TRIGGER_HIT_COUNT_EN
        .hit_count    (hit_count),
`endif
        .hit_wr_ready (hit_wr_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i0_valid = 1'b0; i1_valid = 1'b0;
        i0_tid   = 1'b0; i1_tid   = 1'b0;
        i0_match = 4'b0; i1_match = 4'b0;
        flush_d  = 2'b0;
    endtask

    task automatic check_req(input string tag, input logic v, input logic t, input logic [3:0] m);
        check({tag, "_valid"}, 32'(hit_wr_valid), 32'(v));
        if (v) begin
            check({tag, "_tid"}, 32'(hit_wr_tid), 32'(t));
            check({tag, "_mask"}, 32'(hit_wr_mask), 32'(m));
        end
    endtask

    initial begin
        rst = 1'b1;
        trig_chain = '0; trig_action = '0; hit_wr_ready = 1'b0;
        idle_inputs();
        tick(); tick();
        check("rst_i0_fire", 32'(i0_fire), 32'h0);
        check("rst_i1_fire", 32'(i1_fire), 32'h0);
        check("rst_flags", 32'({i0_halt, i0_exc, i1_halt, i1_exc}), 32'h0);
        check("rst_valid", 32'(hit_wr_valid), 32'h0);
        rst = 1'b0;

        // Unchained i0 hit on thread 0
        i0_valid = 1'b1; i0_match = 4'b0101;
        tick();
        check("t1_fire", 32'(i0_fire), 32'h5);
        check("t1_exc", 32'({i0_halt, i0_exc}), 32'h1);
        check("t1_no_req_yet", 32'(hit_wr_valid), 32'h0);
        idle_inputs();
        tick();
        check("t1_pulse", 32'(i0_fire), 32'h0);
        check_req("t1_req", 1'b1, 1'b0, 4'b0101);
        hit_wr_ready = 1'b1;
        tick();
        check("t1_drained", 32'(hit_wr_valid), 32'h0);
        hit_wr_ready = 1'b0;

        // Chain pair (0,1): a lone match must not fire
        trig_chain[0] = 4'b0001;
        i0_valid = 1'b1; i0_match = 4'b0001;
        tick();
        check("t2_half_fire", 32'(i0_fire), 32'h0);
        idle_inputs();
        tick();
        check("t2_no_hit", 32'(hit_wr_valid), 32'h0);
        i0_valid = 1'b1; i0_match = 4'b0011;
        tick();
        check("t2_full_fire", 32'(i0_fire), 32'h3);
        idle_inputs();
        tick();
        check_req("t2_req", 1'b1, 1'b0, 4'b0011);
        hit_wr_ready = 1'b1;
        tick();
        hit_wr_ready = 1'b0;
        trig_chain = '0;

        // Mixed actions on i1: halt and exception together
        trig_action[0] = 4'b0001;
        i1_valid = 1'b1; i1_tid = 1'b0; i1_match = 4'b0101;
        tick();
        check("t3_fire", 32'(i1_fire), 32'h5);
        check("t3_halt_exc", 32'({i1_halt, i1_exc}), 32'h3);
        check("t3_i0_quiet", 32'({i0_halt, i0_exc, i0_fire}), 32'h0);
        idle_inputs();
        trig_action = '0;
        tick();
        check_req("t3_req", 1'b1, 1'b0, 4'b0101);
        hit_wr_ready = 1'b1;
        tick();
        hit_wr_ready = 1'b0;

        // Flushed thread 1 slot is suppressed
        flush_d = 2'b10;
        i1_valid = 1'b1; i1_tid = 1'b1; i1_match = 4'b1000;
        tick();
        check("t4_fire", 32'(i1_fire), 32'h0);
        check("t4_flags", 32'({i1_halt, i1_exc}), 32'h0);
        idle_inputs();
        tick();
        check("t4_no_hit", 32'(hit_wr_valid), 32'h0);

        // Reset pointer to thread 0, then arbitrate two threads
        rst = 1'b1;
        #1;
        rst = 1'b0;
        i0_valid = 1'b1; i0_tid = 1'b0; i0_match = 4'b0001;
        i1_valid = 1'b1; i1_tid = 1'b1; i1_match = 4'b0010;
        tick();
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            tick();
            check_req($sformatf("t5_hold%0d", k), 1'b1, 1'b0, 4'b0001);
        end
        hit_wr_ready = 1'b1;
        i0_valid = 1'b1; i0_tid = 1'b0; i0_match = 4'b0100;
        tick();
        check_req("t5_grant1", 1'b1, 1'b1, 4'b0010);
        idle_inputs();
        tick();
        check_req("t5_grant0", 1'b1, 1'b0, 4'b0100);
        tick();
        check("t5_idle", 32'(hit_wr_valid), 32'h0);
        hit_wr_ready = 1'b0;

        // Asynchronous reset during an outstanding request
        i0_valid = 1'b1; i0_tid = 1'b1; i0_match = 4'b1111;
        i1_valid = 1'b1; i1_tid = 1'b0; i1_match = 4'b0011;
        tick();
        idle_inputs();
        tick();
        check_req("t6_req", 1'b1, 1'b1, 4'b1111);
        rst = 1'b1;
        #1;
        check("t6_async_drop", 32'(hit_wr_valid), 32'h0);
        #1;
        rst = 1'b0;
        tick();
        check("t6_pend_clr_a", 32'(hit_wr_valid), 32'h0);
        tick();
        check("t6_pend_clr_b", 32'(hit_wr_valid), 32'h0);

`ifdef TRIGGER_HIT_COUNT_EN
        i0_valid = 1'b1; i0_tid = 1'b0; i0_match = 4'b1111;
        i1_valid = 1'b1; i1_tid = 1'b0; i1_match = 4'b1111;
        tick();
        check("cnt_t0_8", 32'(hit_count[0]), 32'd8);
        check("cnt_t1_0", 32'(hit_count[1]), 32'd0);
        for (int k = 0; k < 8200; k++) begin
            @(posedge clk);
        end
        #1;
        check("cnt_sat", 32'(hit_count[0]), 32'hFFFF);
        idle_inputs();
        tick();
        check("cnt_hold", 32'(hit_count[0]), 32'hFFFF);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
